// File: rtl/preg_alloc_ctrl.sv
// preg_alloc_ctrl: sits between rename/commit and the single-port free list.
// It prefetches physical tags into a small FIFO so rename can take 0-2 tags
// per cycle with no latency, and funnels up to two commit frees per cycle
// through a free queue onto the free list's single free port.
module preg_alloc_ctrl #(
    parameter int PHYS_REGS = 64,
    parameter int PF_DEPTH  = 4,
    parameter int FQ_DEPTH  = 8
) (
    input  logic       clk,
    input  logic       reset,
    // rename side
    input  logic [1:0] ren_req,
    output logic       ren_ok,
    output logic [5:0] ren_phys0,
    output logic [5:0] ren_phys1,
    output logic       ren_stall,
    // commit side
    input  logic [1:0] cm_free_en,
    input  logic [5:0] cm_free_phys0,
    input  logic [5:0] cm_free_phys1,
    output logic       cm_ready,
    // free list side
    output logic       fl_alloc_en,
    input  logic [5:0] fl_alloc_phys,
    input  logic       fl_alloc_valid,
    output logic       fl_free_en,
    output logic [5:0] fl_free_phys,
    output logic       err_bad_free
);
    localparam int TAG_W = 6;
    localparam int PF_PW = $clog2(PF_DEPTH);
    localparam int PF_CW = PF_PW + 1;
    localparam int FQ_PW = $clog2(FQ_DEPTH);
    localparam int FQ_CW = FQ_PW + 1;

    // ---------------- prefetch buffer state ----------------
    logic [TAG_W-1:0] pf_mem_q [PF_DEPTH];
    logic [PF_PW-1:0] pf_head_q, pf_head_d, pf_tail_q, pf_tail_d, pf_head_nx;
    logic [PF_CW-1:0] pf_count_q, pf_count_d;
    logic             inflight_q, inflight_d;

    // ---------------- free queue state ----------------
    logic [TAG_W-1:0] fq_mem_q [FQ_DEPTH];
    logic [FQ_PW-1:0] fq_head_q, fq_head_d, fq_tail_q, fq_tail_d, fq_tail_nx;
    logic [FQ_CW-1:0] fq_count_q, fq_count_d;
    logic             err_bad_free_q, err_bad_free_d;

    // ---------------- combinational helpers ----------------
    logic [1:0]       req_eff;
    logic [1:0]       pf_pop_n;
    logic             pf_push;
    logic             alloc_room_ok;
    logic [TAG_W-1:0] free_tag [2];
    logic [1:0]       slot_req;
    logic [1:0]       slot_bad;
    logic [1:0]       fq_accept;
    logic             fq_pop;
    int               fq_room;

    assign free_tag[0] = cm_free_phys0;
    assign free_tag[1] = cm_free_phys1;

    // Per commit slot: a tag is queued only when it names a real register;
    // anything out of range is flagged instead.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        logic in_range;
        assign in_range     = int'(free_tag[gi]) < PHYS_REGS;
        assign slot_req[gi] = cm_free_en[gi] && in_range;
        assign slot_bad[gi] = cm_free_en[gi] && !in_range;
    end

    assign pf_head_nx = pf_head_q + PF_PW'(1);
    assign fq_tail_nx = fq_tail_q + FQ_PW'(1);

    // Keep at most PF_DEPTH tags owned (held + outstanding) so a response
    // always has a slot waiting for it.
    assign alloc_room_ok = (int'(pf_count_q) + int'(inflight_q) + 1) <= PF_DEPTH;
    assign fl_alloc_en   = !reset && alloc_room_ok;
    assign pf_push       = inflight_q && fl_alloc_valid;

    // Rename grant: all-or-nothing on the requested slots; 2'b10 acts as idle.
    always_comb begin
        req_eff  = (ren_req == 2'b10) ? 2'b00 : ren_req;
        ren_ok   = 1'b0;
        pf_pop_n = 2'd0;
        if (!reset) begin
            unique case (req_eff)
                2'b01:   ren_ok = (pf_count_q >= PF_CW'(1));
                2'b11:   ren_ok = (pf_count_q >= PF_CW'(2));
                default: ren_ok = 1'b1;
            endcase
            if (ren_ok) begin
                pf_pop_n = (req_eff == 2'b11) ? 2'd2 : ((req_eff == 2'b01) ? 2'd1 : 2'd0);
            end
        end
    end

    assign ren_stall = !reset && (ren_req != 2'b00) && !ren_ok;
    assign ren_phys0 = reset ? '0 : pf_mem_q[pf_head_q];
    assign ren_phys1 = reset ? '0 : pf_mem_q[pf_head_nx];

    // Free queue admission: slot 0 first, anything beyond the free space is dropped.
    always_comb begin
        fq_room      = FQ_DEPTH - int'(fq_count_q);
        fq_accept[0] = slot_req[0] && (fq_room >= 1);
        fq_accept[1] = slot_req[1] && (fq_room >= (fq_accept[0] ? 2 : 1));
    end

    assign fq_pop       = (fq_count_q != '0);
    assign fl_free_en   = !reset && fq_pop;
    assign fl_free_phys = reset ? '0 : fq_mem_q[fq_head_q];
    assign cm_ready     = reset || ((FQ_DEPTH - int'(fq_count_q)) >= 2);
    assign err_bad_free = err_bad_free_q;

    // Next-state for pointers, counts, the inflight flag and the sticky error.
    always_comb begin
        inflight_d     = fl_alloc_en;
        pf_head_d      = pf_head_q + PF_PW'(pf_pop_n);
        pf_tail_d      = pf_tail_q + PF_PW'(pf_push);
        pf_count_d     = pf_count_q + PF_CW'(pf_push) - PF_CW'(pf_pop_n);
        fq_head_d      = fq_head_q + FQ_PW'(fq_pop);
        fq_tail_d      = fq_tail_q + FQ_PW'(fq_accept[0]) + FQ_PW'(fq_accept[1]);
        fq_count_d     = fq_count_q + FQ_CW'(fq_accept[0]) + FQ_CW'(fq_accept[1])
                         - FQ_CW'(fq_pop);
        err_bad_free_d = err_bad_free_q | (|slot_bad);
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pf_head_q      <= '0;
            pf_tail_q      <= '0;
            pf_count_q     <= '0;
            inflight_q     <= 1'b0;
            fq_head_q      <= '0;
            fq_tail_q      <= '0;
            fq_count_q     <= '0;
            err_bad_free_q <= 1'b0;
        end else begin
            pf_head_q      <= pf_head_d;
            pf_tail_q      <= pf_tail_d;
            pf_count_q     <= pf_count_d;
            inflight_q     <= inflight_d;
            fq_head_q      <= fq_head_d;
            fq_tail_q      <= fq_tail_d;
            fq_count_q     <= fq_count_d;
            err_bad_free_q <= err_bad_free_d;
        end
    end

    // Storage writes: captured alloc response into the prefetch tail,
    // accepted commit frees into the free queue tail (slot 0 ahead of slot 1).
    always_ff @(posedge clk) begin
        if (!reset && pf_push) begin
            pf_mem_q[pf_tail_q] <= fl_alloc_phys;
        end
        if (!reset && fq_accept[0]) begin
            fq_mem_q[fq_tail_q] <= free_tag[0];
        end
        if (!reset && fq_accept[1]) begin
            fq_mem_q[fq_accept[0] ? fq_tail_nx : fq_tail_q] <= free_tag[1];
        end
    end

    // Protocol checks on the callers: no lone slot-1 rename, no frees without cm_ready.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (ren_req != 2'b10);
            assert (cm_ready || (cm_free_en == 2'b00));
        end
    end

endmodule

// File: tb/tb_preg_alloc_ctrl.sv
// Bench for preg_alloc_ctrl: a behavioural free list feeds the DUT, and two
// scoreboards (prefetch tags, free-queue tags) hold what the DUT should emit.
module tb_preg_alloc_ctrl;
    localparam int PF_DEPTH = 4;
    localparam int FQ_DEPTH = 8;
    localparam int NREGS    = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    always #5 clk = ~clk;

    // main DUT (64 registers)
    logic [1:0] ren_req = 2'b00;
    logic       ren_ok, ren_stall, cm_ready, fl_alloc_en, fl_free_en, err_bad_free;
    logic [5:0] ren_phys0, ren_phys1, fl_free_phys;
    logic [1:0] cm_free_en = 2'b00;
    logic [5:0] cm_free_phys0 = '0, cm_free_phys1 = '0;
    logic [5:0] fl_alloc_phys = '0;
    logic       fl_alloc_valid = 1'b0;

    // second DUT (48 registers) for out-of-range frees
    logic [1:0] b_cm_free_en = 2'b00;
    logic [5:0] b_cm_free_phys0 = '0, b_cm_free_phys1 = '0;
    logic       b_ren_ok, b_ren_stall, b_cm_ready, b_fl_alloc_en, b_fl_free_en, b_err;
    logic [5:0] b_ren_phys0, b_ren_phys1, b_fl_free_phys;

    preg_alloc_ctrl #(.PHYS_REGS(NREGS), .PF_DEPTH(PF_DEPTH), .FQ_DEPTH(FQ_DEPTH)) u_dut (
        .clk(clk), .reset(reset),
        .ren_req(ren_req), .ren_ok(ren_ok), .ren_phys0(ren_phys0), .ren_phys1(ren_phys1),
        .ren_stall(ren_stall),
        .cm_free_en(cm_free_en), .cm_free_phys0(cm_free_phys0), .cm_free_phys1(cm_free_phys1),
        .cm_ready(cm_ready),
        .fl_alloc_en(fl_alloc_en), .fl_alloc_phys(fl_alloc_phys), .fl_alloc_valid(fl_alloc_valid),
        .fl_free_en(fl_free_en), .fl_free_phys(fl_free_phys), .err_bad_free(err_bad_free)
    );

    preg_alloc_ctrl #(.PHYS_REGS(48), .PF_DEPTH(PF_DEPTH), .FQ_DEPTH(FQ_DEPTH)) u_dut48 (
        .clk(clk), .reset(reset),
        .ren_req(2'b00), .ren_ok(b_ren_ok), .ren_phys0(b_ren_phys0), .ren_phys1(b_ren_phys1),
        .ren_stall(b_ren_stall),
        .cm_free_en(b_cm_free_en), .cm_free_phys0(b_cm_free_phys0), .cm_free_phys1(b_cm_free_phys1),
        .cm_ready(b_cm_ready),
        .fl_alloc_en(b_fl_alloc_en), .fl_alloc_phys(6'd0), .fl_alloc_valid(1'b0),
        .fl_free_en(b_fl_free_en), .fl_free_phys(b_fl_free_phys), .err_bad_free(b_err)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [5:0] fl_pool [$];   // free list contents
    logic [5:0] pf_exp  [$];   // tags the DUT should hold, head first
    logic [5:0] fq_exp  [$];   // tags the DUT should drain, head first
    logic       inflight_m = 1'b0;
    int         grant_cnt = 0;
    logic [5:0] last_grant = '0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: compare at negedge, advance the models, then update the
    // free list outputs 1 ns after the rising edge.
    task automatic tick();
        logic       s_alloc_en, s_free_en, exp_ok, exp_alloc, inflight_next;
        logic [5:0] s_free_phys;
        int         npop;
        @(negedge clk);
        s_alloc_en    = fl_alloc_en;
        s_free_en     = fl_free_en;
        s_free_phys   = fl_free_phys;
        inflight_next = 1'b0;
        if (reset) begin
            check_val("rst_alloc_en", fl_alloc_en, 0);
            check_val("rst_ren_ok", ren_ok, 0);
            check_val("rst_ren_stall", ren_stall, 0);
            check_val("rst_cm_ready", cm_ready, 1);
            check_val("rst_free_en", fl_free_en, 0);
            check_val("rst_err", err_bad_free, 0);
            pf_exp.delete();
            fq_exp.delete();
        end else begin
            exp_alloc = (pf_exp.size() + int'(inflight_m) + 1) <= PF_DEPTH;
            check_val("alloc_en", fl_alloc_en, exp_alloc);
            case (ren_req)
                2'b01:   exp_ok = pf_exp.size() >= 1;
                2'b11:   exp_ok = pf_exp.size() >= 2;
                default: exp_ok = 1'b1;
            endcase
            check_val("ren_ok", ren_ok, exp_ok);
            check_val("ren_stall", ren_stall, (ren_req != 2'b00) && !exp_ok);
            npop = !exp_ok ? 0 : (ren_req == 2'b11) ? 2 : (ren_req == 2'b01) ? 1 : 0;
            if (npop >= 1) check_val("ren_phys0", ren_phys0, pf_exp[0]);
            if (npop == 2) check_val("ren_phys1", ren_phys1, pf_exp[1]);
            check_val("cm_ready", cm_ready, (FQ_DEPTH - fq_exp.size()) >= 2);
            check_val("free_en", fl_free_en, fq_exp.size() != 0);
            if (fq_exp.size() != 0) begin
                check_val("free_phys", fl_free_phys, fq_exp[0]);
                $display("[TB] free drain tag %0d", fl_free_phys);
                void'(fq_exp.pop_front());
            end
            check_val("err_bad_free", err_bad_free, 0);
            for (int i = 0; i < npop; i++) begin
                last_grant = pf_exp.pop_front();
                grant_cnt++;
                $display("[TB] rename grant tag %0d (total %0d)", last_grant, grant_cnt);
            end
            if (inflight_m && fl_alloc_valid) pf_exp.push_back(fl_alloc_phys);
            if (cm_free_en[0]) fq_exp.push_back(cm_free_phys0);
            if (cm_free_en[1]) fq_exp.push_back(cm_free_phys1);
            inflight_next = exp_alloc;
        end
        @(posedge clk);
        #1;
        inflight_m = inflight_next;
        // free list: the returned tag is visible to an alloc at the same edge
        if (s_free_en) fl_pool.push_back(s_free_phys);
        if (s_alloc_en && fl_pool.size() != 0) begin
            fl_alloc_valid = 1'b1;
            fl_alloc_phys  = fl_pool.pop_front();
        end else begin
            fl_alloc_valid = 1'b0;
            fl_alloc_phys  = '0;
        end
    endtask

    initial begin
        int  cyc, stall_run, wait_cyc, n_burst;
        bit  saw_low;
        for (int i = 0; i < NREGS; i++) fl_pool.push_back(6'(i));

        // reset, then idle fill
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_val("idle_alloc_off", fl_alloc_en, 0);
        check_val("idle_ren_ok", ren_ok, 1);
        check_val("head_tags_01", {ren_phys1, ren_phys0}, {6'd1, 6'd0});

        // two double renames
        ren_req = 2'b11;
        tick();
        check_val("head_tags_23", {ren_phys1, ren_phys0}, {6'd3, 6'd2});
        tick();
        ren_req = 2'b00;
        for (int i = 0; i < 4; i++) tick();
        check_val("refill_tags_45", {ren_phys1, ren_phys0}, {6'd5, 6'd4});

        // exhaust the free list one tag per cycle
        ren_req   = 2'b01;
        cyc       = 0;
        stall_run = 0;
        while (stall_run < 4 && cyc < 300) begin
            tick();
            cyc++;
            stall_run = ren_stall ? stall_run + 1 : 0;
        end
        check_val("exhaust_in_time", cyc < 300, 1);
        check_val("grant_count", grant_cnt, 64);
        check_val("last_grant", last_grant, 63);
        check_val("stall_when_empty", ren_stall, 1);

        // free tag 7 and watch it come back to rename
        cm_free_en    = 2'b01;
        cm_free_phys0 = 6'd7;
        tick();
        cm_free_en = 2'b00;
        wait_cyc   = 0;
        while (grant_cnt == 64 && wait_cyc < 8) begin
            tick();
            wait_cyc++;
        end
        ren_req = 2'b00;
        check_val("free7_regrant", last_grant, 7);
        check_val("free7_within_3", wait_cyc <= 3, 1);

        // double-free burst of tags 10/11 while cm_ready allows
        cm_free_phys0 = 6'd10;
        cm_free_phys1 = 6'd11;
        n_burst = 0;
        saw_low = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (!cm_ready) saw_low = 1'b1;
            if (cm_ready && n_burst < 8) begin
                cm_free_en = 2'b11;
                n_burst++;
            end else begin
                cm_free_en = 2'b00;
            end
            tick();
        end
        cm_free_en = 2'b00;
        check_val("burst_ready_fell", saw_low, 1);
        check_val("burst_drained", fl_free_en, 0);
        check_val("burst_ready_back", cm_ready, 1);

        // out-of-range free on the 48-register instance
        b_cm_free_en    = 2'b11;
        b_cm_free_phys0 = 6'd63;
        b_cm_free_phys1 = 6'd6;
        tick();
        b_cm_free_en = 2'b00;
        check_val("bad_free_en", b_fl_free_en, 1);
        check_val("bad_free_phys", b_fl_free_phys, 6);
        check_val("bad_err_set", b_err, 1);
        tick();
        check_val("bad_63_not_queued", b_fl_free_en, 0);
        check_val("bad_err_sticky", b_err, 1);
        tick();
        check_val("bad_err_sticky2", b_err, 1);

        // reset with an alloc in flight and three queued frees
        ren_req       = 2'b11;
        cm_free_en    = 2'b11;
        cm_free_phys0 = 6'd20;
        cm_free_phys1 = 6'd21;
        tick();
        ren_req       = 2'b00;
        cm_free_phys0 = 6'd22;
        cm_free_phys1 = 6'd23;
        tick();
        cm_free_en = 2'b00;
        check_val("pre_rst_free_en", fl_free_en, 1);
        check_val("pre_rst_stale_resp", fl_alloc_valid, 1);
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        ren_req = 2'b01;
        #1;
        check_val("post_rst_free_en", fl_free_en, 0);
        check_val("post_rst_cm_ready", cm_ready, 1);
        check_val("post_rst_no_stale", ren_ok, 0);
        check_val("post_rst_err48", b_err, 0);
        for (int i = 0; i < 6; i++) tick();
        ren_req = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
        $fatal(1, "timeout");
    end

endmodule
